// File: rtl/hpel_fetch_sched_if.sv
// Bundle of the start/status, reference-memory read and six-tap window
// handshake signals of the half-pel fetch sequencer.
interface hpel_fetch_sched_if;
  logic        start;
  logic [7:0]  centre;
  logic        busy;
  logic        done;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        win_valid;
  logic        win_ready;
  logic [47:0] win_data;
  logic [2:0]  win_row;

  modport master (
    input  start, centre, mem_rdata, win_ready,
    output busy, done, mem_rd, mem_addr, win_valid, win_data, win_row
  );

  modport slave (
    output start, centre, mem_rdata, win_ready,
    input  busy, done, mem_rd, mem_addr, win_valid, win_data, win_row
  );
endinterface

// File: rtl/hpel_fetch_sched.sv
// Half-pel fetch sequencer: walks the 6x6 neighbourhood of a centre pixel and
// presents one 48-bit row window per handshake. HPEL_CLAMP_EN selects edge clamping.
module hpel_fetch_sched (
  input logic               clk,
  input logic               rst,
  hpel_fetch_sched_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  centre_q;
  logic [2:0]  k_q, j_q;
  logic        cap_q;
  logic [2:0]  cap_idx_q;
  logic [47:0] win_q;
  logic [3:0]  row_a, col_a;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (bus.start) state_nx = S_FETCH;
      S_FETCH:   if (j_q == 3'd5) state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_PRESENT;
      S_PRESENT: if (bus.win_ready) state_nx = (k_q == 3'd5) ? S_DONE : S_FETCH;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

`ifdef HPEL_CLAMP_EN
  logic signed [5:0] row_s, col_s;
  always_comb begin
    row_s = $signed({2'b00, centre_q[7:4]}) + $signed({3'b000, k_q}) - 6'sd2;
    col_s = $signed({2'b00, centre_q[3:0]}) + $signed({3'b000, j_q}) - 6'sd2;
    row_a = row_s[5] ? 4'd0 : ((row_s > 6'sd15) ? 4'hF : row_s[3:0]);
    col_a = col_s[5] ? 4'd0 : ((col_s > 6'sd15) ? 4'hF : col_s[3:0]);
  end
`else
  always_comb begin
    row_a = centre_q[7:4] + {1'b0, k_q} - 4'd2;
    col_a = centre_q[3:0] + {1'b0, j_q} - 4'd2;
  end
`endif

  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.done      = (state == S_DONE);
    bus.mem_rd    = (state == S_FETCH);
    bus.mem_addr  = (state == S_FETCH) ? {row_a, col_a} : '0;
    bus.win_valid = (state == S_PRESENT);
    bus.win_data  = win_q;
    bus.win_row   = k_q;
  end

  // Read data trails its strobe by one cycle, so the byte lane is carried
  // alongside a delayed strobe; this also covers the CAPTURE write of byte 5.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      centre_q  <= '0;
      k_q       <= '0;
      j_q       <= '0;
      cap_q     <= 1'b0;
      cap_idx_q <= '0;
      win_q     <= '0;
    end else begin
      cap_q     <= bus.mem_rd;
      cap_idx_q <= j_q;
      if (cap_q) win_q[{cap_idx_q, 3'b000} +: 8] <= bus.mem_rdata;
      unique case (state)
        S_IDLE: if (bus.start) begin
          centre_q <= bus.centre;
          k_q      <= '0;
          j_q      <= '0;
        end
        S_FETCH: j_q <= j_q + 3'd1;
        S_PRESENT: if (bus.win_ready) begin
          j_q <= '0;
          if (k_q != 3'd5) k_q <= k_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hpel_fetch_sched.sv
// Randomized self-checking bench for hpel_fetch_sched against an arithmetic
// neighbourhood model; honours HPEL_CLAMP_EN.
module tb_hpel_fetch_sched;

  logic clk = 1'b0;
  logic rst;
  hpel_fetch_sched_if bus();

  hpel_fetch_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [256];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;
  int          ready_mode = 0;
  int          stall_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [47:0] model_win(input logic [7:0] c, input int k);
    logic [47:0] w;
    int r, col;
    w = '0;
    for (int j = 0; j < 6; j++) begin
      r   = int'(c[7:4]) + k - 2;
      col = int'(c[3:0]) + j - 2;
`ifdef HPEL_CLAMP_EN
      r   = (r < 0) ? 0 : ((r > 15) ? 15 : r);
      col = (col < 0) ? 0 : ((col > 15) ? 15 : col);
`else
      r   = (r + 16) % 16;
      col = (col + 16) % 16;
`endif
      w[8*j +: 8] = mem[8'(r * 16 + col)];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.win_ready = 1'b1;
      1: bus.win_ready = ($urandom_range(0, 3) != 0);
      default:
        if (bus.win_valid && bus.win_row == 3'd2 && stall_cnt < 5) begin
          bus.win_ready = 1'b0;
          stall_cnt++;
        end else bus.win_ready = 1'b1;
    endcase
  end

  logic [47:0] exp_data [$];
  logic [2:0]  exp_row  [$];
  logic [47:0] got [8];
  logic [47:0] held_data;
  logic [2:0]  held_row;
  bit          busy_q = 0, stall_pending = 0;
  int          acc_cyc = 0, first_valid_cyc = -1, done_cyc = 0;
  int          busy_cycles = 0, win_in_run = 0, done_count = 0;

  always @(negedge clk) begin
    if (!rst) begin
      stall_pending = 0;
      busy_q        = 0;
    end else begin
      if (bus.busy && !busy_q) begin
        acc_cyc = cyc; first_valid_cyc = -1; busy_cycles = 0; win_in_run = 0;
        for (int k = 0; k < 6; k++) begin
          exp_data.push_back(model_win(bus.centre, k));
          exp_row.push_back(3'(k));
        end
      end
      if (bus.busy) busy_cycles++;
      if (stall_pending) begin
        check("valid_held", 64'(bus.win_valid), 64'd1);
        check("stall_data", 64'(bus.win_data), 64'(held_data));
        check("stall_row", 64'(bus.win_row), 64'(held_row));
      end
      if (bus.win_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        check("rd_in_present", 64'(bus.mem_rd), 64'd0);
        if (bus.win_ready) begin
          stall_pending = 0;
          check("win_expected", 64'(exp_data.size() > 0), 64'd1);
          if (exp_data.size() > 0) begin
            check("win_data", 64'(bus.win_data), 64'(exp_data.pop_front()));
            check("win_row", 64'(bus.win_row), 64'(exp_row.pop_front()));
          end
          got[bus.win_row] = bus.win_data;
          win_in_run++;
        end else begin
          stall_pending = 1;
          held_data = bus.win_data;
          held_row  = bus.win_row;
        end
      end else stall_pending = 0;
      if (bus.done) begin
        done_count++;
        done_cyc = cyc;
        check("done_busy", 64'(bus.busy), 64'd1);
        check("win_per_run", 64'(win_in_run), 64'd6);
        check("queue_empty", 64'(exp_data.size()), 64'd0);
        win_in_run = 0;
      end
      busy_q = bus.busy;
    end
  end

  task automatic start_run(input logic [7:0] c);
    int n = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.centre = c;
    while (!bus.busy && n < 20) begin @(negedge clk); n++; end
    check("start_accepted", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.centre = 8'($urandom);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    bit seen = 0;
    while (!seen && n < limit) begin
      @(negedge clk); n++;
      if (bus.done) seen = 1;
    end
    check("done_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"},     64'(bus.busy), 64'd0);
    check({pfx, "_done"},     64'(bus.done), 64'd0);
    check({pfx, "_mem_rd"},   64'(bus.mem_rd), 64'd0);
    check({pfx, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    check({pfx, "_valid"},    64'(bus.win_valid), 64'd0);
    check({pfx, "_data"},     64'(bus.win_data), 64'd0);
    check({pfx, "_row"},      64'(bus.win_row), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1, n;
    rst = 1'b1; bus.start = 1'b0; bus.centre = '0; bus.win_ready = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);
    #2 rst = 1'b0;
    #10;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b1;

    // Identity memory, centre 0x55, ready held high.
    start_run(8'h55);
    wait_done(200);
    check("first_valid_lat", 64'(first_valid_cyc - acc_cyc), 64'd7);
    check("done_lat", 64'(done_cyc - acc_cyc), 64'd48);
    check("busy_cycles", 64'(busy_cycles), 64'd49);
    check("c55_row0", 64'(got[0]), 64'h0000_3837_3635_3433);
    check("c55_row5", 64'(got[5]), 64'h0000_8887_8685_8483);

    // Top-left corner: wrap or clamp.
    start_run(8'h00);
    wait_done(200);
`ifdef HPEL_CLAMP_EN
    check("c00_row0", 64'(got[0]), 64'h0000_0302_0100_0000);
`else
    check("c00_row0", 64'(got[0]), 64'h0000_E3E2_E1E0_EFEE);
`endif

    // Five-cycle stall on row 2.
    ready_mode = 2; stall_cnt = 0;
    start_run(8'h37);
    wait_done(200);
    check("stall_done_lat", 64'(done_cyc - acc_cyc), 64'd53);
    ready_mode = 0;

    // Start with a different centre while busy must be ignored.
    d0 = done_count;
    start_run(8'h2A);
    repeat (10) @(posedge clk);
    #1 bus.start = 1'b1; bus.centre = 8'h99;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(200);
    repeat (3) @(posedge clk);
    check("ignored_start_dones", 64'(done_count - d0), 64'd1);
    check("ignored_start_idle", 64'(bus.busy), 64'd0);

    // Asynchronous reset during row 3 fetch.
    d0 = done_count;
    start_run(8'hC4);
    n = 0;
    while (!(bus.mem_rd && bus.win_row == 3'd3) && n < 200) begin @(negedge clk); n++; end
    check("reached_row3", 64'(bus.win_row), 64'd3);
    #1 rst = 1'b0;
    #1 check_all_zero("midrst");
    exp_data.delete(); exp_row.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    check("midrst_no_done", 64'(done_count - d0), 64'd0);
    start_run(8'hC4);
    wait_done(200);
    check("midrst_rerun_done", 64'(done_count - d0), 64'd1);

    // Start held high: two runs back to back.
    @(posedge clk); #1 bus.start = 1'b1; bus.centre = 8'h6B;
    wait_done(200);
    d1 = done_cyc;
    wait_done(200);
    bus.start = 1'b0;
    check("b2b_gap", 64'(done_cyc - d1), 64'd50);
    repeat (3) @(posedge clk);
    check("b2b_idle", 64'(bus.busy), 64'd0);

    // Random memory, centres and ready back-pressure.
    ready_mode = 1;
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      start_run(8'($urandom));
      wait_done(2000);
    end
    ready_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
